// File: rtl/seq_pkg.sv
// Shared state encoding and sizing helper for the drum-machine sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_LOAD_BPM      = 3'd0,
    S_LOAD_BPM_WAIT = 3'd1,
    S_LOAD_INS      = 3'd2,
    S_LOAD_INS_WAIT = 3'd3,
    S_PLAY          = 3'd4
  } seq_state_t;

  function automatic int seq_step_w(input int steps);
    return (steps < 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/seq_step_counter.sv
// Modulo-STEPS beat counter with live-beat flag, step strobe and bar marker.
module seq_step_counter #(
  parameter int STEPS  = 8,
  parameter int STEP_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  output logic [STEP_W-1:0] step,
  output logic              step_valid,
  output logic              step_strobe,
  output logic              bar_start
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              valid_q, valid_d;
  logic              strobe_q, strobe_d;
  logic              bar_q, bar_d;

  always_comb begin
    step_d   = step_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    bar_d    = 1'b0;
    if (clr) begin
      step_d  = '0;
      valid_d = 1'b0;
    end else if (en) begin
      // First tick after entering play lands on beat 0.
      if (!valid_q || step_q == STEP_W'(STEPS - 1))
        step_d = '0;
      else
        step_d = step_q + 1'b1;
      valid_d  = 1'b1;
      strobe_d = 1'b1;
      bar_d    = (step_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      bar_q    <= 1'b0;
    end else begin
      step_q   <= step_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
      bar_q    <= bar_d;
    end
  end

  assign step        = step_q;
  assign step_valid  = valid_q;
  assign step_strobe = strobe_q;
  assign bar_start   = bar_q;

endmodule

// File: rtl/seq_control_param.sv
// Drum-machine sequencer: BPM/instrument load walk, then looping play.
// Optional SEQ_PAUSE_EN adds a pause input that freezes the beat in play.
module seq_control_param
  import seq_pkg::*;
#(
  parameter int NUM_INS = 4,
  parameter int STEPS   = 8,
  parameter int STEP_W  = seq_step_w(STEPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               stop,
  input  logic               beat_tick,
`ifdef SEQ_PAUSE_EN
  input  logic               pause,
`endif
  output logic               ld_bpm,
  output logic [NUM_INS-1:0] ld_ins,
  output logic               play,
  output logic [STEP_W-1:0]  step,
  output logic               step_valid,
  output logic               step_strobe,
  output logic               bar_start
);

  localparam int IDX_W = (NUM_INS > 1) ? $clog2(NUM_INS) : 1;

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             adv, clr, pause_i;

`ifdef SEQ_PAUSE_EN
  assign pause_i = pause;
`else
  assign pause_i = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ld_bpm  = 1'b0;
    ld_ins  = '0;
    play    = 1'b0;
    adv     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_LOAD_BPM: begin
        ld_bpm = 1'b1;
        if (go) state_d = S_LOAD_BPM_WAIT;
      end
      S_LOAD_BPM_WAIT: begin
        if (!go) begin
          state_d = S_LOAD_INS;
          idx_d   = '0;
        end
      end
      S_LOAD_INS: begin
        ld_ins = NUM_INS'(1) << idx_q;
        if (go) state_d = S_LOAD_INS_WAIT;
      end
      S_LOAD_INS_WAIT: begin
        if (!go) begin
          if (idx_q == IDX_W'(NUM_INS - 1)) begin
            state_d = S_PLAY;
          end else begin
            state_d = S_LOAD_INS;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        play = 1'b1;
        // stop wins over a coincident tick
        if (stop) begin
          state_d = S_LOAD_BPM;
          idx_d   = '0;
          clr     = 1'b1;
        end else if (beat_tick && !pause_i) begin
          adv = 1'b1;
        end
      end
      default: begin
        state_d = S_LOAD_BPM;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD_BPM;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  seq_step_counter #(
    .STEPS  (STEPS),
    .STEP_W (STEP_W)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .en          (adv),
    .clr         (clr),
    .step        (step),
    .step_valid  (step_valid),
    .step_strobe (step_strobe),
    .bar_start   (bar_start)
  );

endmodule

// File: tb/tb_seq_control_param.sv
// Random + directed bench for seq_control_param against a phase-level model.
module tb_seq_control_param;

  logic clk = 1'b0;
  logic reset, go, stop, beat_tick, pause;

  logic       a_ld_bpm, a_play, a_valid, a_strobe, a_bar;
  logic [3:0] a_ld_ins;
  logic [2:0] a_step;
  logic       b_ld_bpm, b_play, b_valid, b_strobe, b_bar;
  logic [0:0] b_ld_ins;
  logic [0:0] b_step;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_control_param #(.NUM_INS(4), .STEPS(8)) dut_a (
    .clk(clk), .reset(reset), .go(go), .stop(stop),
    .beat_tick(beat_tick),
`ifdef SEQ_PAUSE_EN
    .pause(pause),
`endif
    .ld_bpm(a_ld_bpm), .ld_ins(a_ld_ins), .play(a_play),
    .step(a_step), .step_valid(a_valid),
    .step_strobe(a_strobe), .bar_start(a_bar)
  );

  seq_control_param #(.NUM_INS(1), .STEPS(2)) dut_b (
    .clk(clk), .reset(reset), .go(go), .stop(stop),
    .beat_tick(beat_tick),
`ifdef SEQ_PAUSE_EN
    .pause(pause),
`endif
    .ld_bpm(b_ld_bpm), .ld_ins(b_ld_ins), .play(b_play),
    .step(b_step), .step_valid(b_valid),
    .step_strobe(b_strobe), .bar_start(b_bar)
  );

  // pos: 0 = BPM slot, k = instrument k-1; held = key down awaiting release
  typedef struct {
    int pos;
    bit held;
    bit playing;
    int step;
    bit valid;
    bit strobe;
    bit bar;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t m_init();
    mdl_t m;
    m = '{default: 0};
    return m;
  endfunction

  function automatic mdl_t nxt(mdl_t m, int ni, int st,
                               bit g, bit s, bit t, bit p);
    mdl_t n;
    n = m;
    n.strobe = 0;
    n.bar = 0;
    if (m.playing) begin
      if (s) begin
        n = m_init();
      end else if (t && !p) begin
        n.step = m.valid ? (m.step + 1) % st : 0;
        n.valid = 1;
        n.strobe = 1;
        n.bar = (n.step == 0);
      end
    end else if (!m.held) begin
      if (g) n.held = 1;
    end else if (!g) begin
      n.held = 0;
      if (m.pos == ni) n.playing = 1;
      else n.pos = m.pos + 1;
    end
    return n;
  endfunction

  function automatic int e_bpm(mdl_t m);
    return (!m.playing && m.pos == 0 && !m.held) ? 1 : 0;
  endfunction

  function automatic int e_ins(mdl_t m);
    if (!m.playing && m.pos > 0 && !m.held) return 1 << (m.pos - 1);
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("a_ld_bpm", 32'(a_ld_bpm), e_bpm(ma));
    chk("a_ld_ins", 32'(a_ld_ins), e_ins(ma));
    chk("a_play",   32'(a_play),   32'(ma.playing));
    chk("a_step",   32'(a_step),   ma.step);
    chk("a_valid",  32'(a_valid),  32'(ma.valid));
    chk("a_strobe", 32'(a_strobe), 32'(ma.strobe));
    chk("a_bar",    32'(a_bar),    32'(ma.bar));
    chk("b_ld_bpm", 32'(b_ld_bpm), e_bpm(mb));
    chk("b_ld_ins", 32'(b_ld_ins), e_ins(mb));
    chk("b_play",   32'(b_play),   32'(mb.playing));
    chk("b_step",   32'(b_step),   mb.step);
    chk("b_valid",  32'(b_valid),  32'(mb.valid));
    chk("b_strobe", 32'(b_strobe), 32'(mb.strobe));
    chk("b_bar",    32'(b_bar),    32'(mb.bar));
  endtask

  task automatic cyc(input bit g, input bit s, input bit t);
    go = g;
    stop = s;
    beat_tick = t;
    @(posedge clk);
    ma = nxt(ma, 4, 8, g, s, t, pause);
    mb = nxt(mb, 1, 2, g, s, t, pause);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    ma = m_init();
    mb = m_init();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  task automatic walk(input int hold);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0);
      for (int j = 0; j < hold; j++) cyc(1, 0, 0);
      cyc(0, 0, 0);
      cyc(0, 0, 0);
    end
  endtask

  task automatic tick_to(input int tgt, input string tag);
    int n;
    n = 0;
    while (!(ma.valid && ma.step == tgt) && n < 20) begin
      cyc(0, 0, 1);
      n++;
    end
    chk(tag, 32'(a_step), tgt);
  endtask

  initial begin
    reset = 1'b1;
    go = 0;
    stop = 0;
    beat_tick = 0;
    pause = 0;
    ma = m_init();
    mb = m_init();
    #2;
    check_all();
    @(negedge clk);
    check_all();
    reset = 1'b0;

    walk(20);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
    tick_to(3, "reach_step3");
    cyc(0, 1, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    walk(1);
    tick_to(5, "reach_step5");
    cyc(0, 0, 0);
    do_reset();

`ifdef SEQ_PAUSE_EN
    walk(1);
    tick_to(2, "reach_step2");
    pause = 1;
    repeat (3) cyc(0, 0, 1);
    pause = 0;
    cyc(0, 0, 1);
    chk("pause_resume", 32'(a_step), 3);
`endif

    for (int i = 0; i < 3000; i++) begin
      bit g;
      g = ($urandom_range(0, 3) == 0) ? !go : go;
`ifdef SEQ_PAUSE_EN
      pause = ($urandom_range(0, 5) == 0);
`endif
      cyc(g, $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    go = 1;
    do_reset();
    cyc(1, 0, 0);
    cyc(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
